// File: rtl/rename_map_table.sv
// rename_map_table
// ----------------
// Two-wide register rename stage. Takes up to two instructions per group,
// maps their architectural sources to physical registers through the
// speculative map, gives each writing slot a fresh physical destination
// popped from the freelist, and reports the mapping each destination
// replaced (old_prd) so commit can later return it to the freelist.
//
// Two maps are held:
//   spec_map - updated as groups are renamed (speculative view)
//   arch_map - updated by commit (architectural view)
// A flush copies arch_map (including commits of the same cycle) into spec_map.
//
// Handshakes (valid/ready, both sides):
//   A transfer happens on a rising clock edge where valid && ready are both 1.
//   The producer holds valid and its data stable until that transfer. ready
//   may depend combinationally on valid and inputs, never the reverse.
//   in_ready is combinational from flush, out_valid/out_ready and free_count.
//   out_valid is registered; out data is held while out_valid && !out_ready.
//
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   in_valid / in_ready   rename group handshake
//   in_slot_valid[1:0]    per-slot instruction valid
//   in_rs1/in_rs2/in_rd   per-slot architectural indices (slot k at [k*L +: L])
//   in_rd_wen[1:0]        per-slot destination write enable
//   free_count            entries currently available in the freelist
//   allocK_valid/_data    freelist pop requests and head/head+1 entries
//   out_valid / out_ready renamed group handshake (1-cycle latency)
//   out_slot_valid        per-slot valid of the renamed group
//   out_prs1/out_prs2     physical sources (slot k at [k*P +: P])
//   out_prd / out_old_prd new and previous physical destination per slot
//   commit_valid/_rd/_prd architectural map update, two slots
//   flush                 discard speculative state
//   stall_cnt             (RENAME_STALL_CNT_EN only) saturating count of
//                         cycles a valid group waited on the freelist
//
// Build option: define RENAME_STALL_CNT_EN to add the stall_cnt port/counter.

module rename_map_table #(
  parameter int ARCH_REGS      = 32,
  parameter int LOG_ARCH_REGS  = 5,
  parameter int PREG_IDX_WIDTH = 6,
  parameter int FREE_CNT_WIDTH = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_slot_valid,
  input  logic [2*LOG_ARCH_REGS-1:0]    in_rs1,
  input  logic [2*LOG_ARCH_REGS-1:0]    in_rs2,
  input  logic [2*LOG_ARCH_REGS-1:0]    in_rd,
  input  logic [1:0]                    in_rd_wen,
  input  logic [FREE_CNT_WIDTH-1:0]     free_count,
  output logic                          alloc0_valid,
  input  logic [PREG_IDX_WIDTH-1:0]     alloc0_data,
  output logic                          alloc1_valid,
  input  logic [PREG_IDX_WIDTH-1:0]     alloc1_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    out_slot_valid,
  output logic [2*PREG_IDX_WIDTH-1:0]   out_prs1,
  output logic [2*PREG_IDX_WIDTH-1:0]   out_prs2,
  output logic [2*PREG_IDX_WIDTH-1:0]   out_prd,
  output logic [2*PREG_IDX_WIDTH-1:0]   out_old_prd,
  input  logic [1:0]                    commit_valid,
  input  logic [2*LOG_ARCH_REGS-1:0]    commit_rd,
  input  logic [2*PREG_IDX_WIDTH-1:0]   commit_prd,
`ifdef RENAME_STALL_CNT_EN
  output logic [31:0]                   stall_cnt,
`endif
  input  logic                          flush
);

  localparam int L = LOG_ARCH_REGS;
  localparam int P = PREG_IDX_WIDTH;

  // --------------------------------------------------------------------
  // Map storage
  // --------------------------------------------------------------------
  logic [P-1:0] spec_map     [ARCH_REGS];
  logic [P-1:0] arch_map     [ARCH_REGS];
  logic [P-1:0] arch_map_nxt [ARCH_REGS];

  // --------------------------------------------------------------------
  // Per-slot field extraction
  // --------------------------------------------------------------------
  logic [L-1:0] rs1_0, rs1_1, rs2_0, rs2_1, rd_0, rd_1;
  logic [L-1:0] c_rd_0, c_rd_1;
  logic [P-1:0] c_prd_0, c_prd_1;

  assign rs1_0   = in_rs1[L-1:0];
  assign rs1_1   = in_rs1[2*L-1:L];
  assign rs2_0   = in_rs2[L-1:0];
  assign rs2_1   = in_rs2[2*L-1:L];
  assign rd_0    = in_rd[L-1:0];
  assign rd_1    = in_rd[2*L-1:L];
  assign c_rd_0  = commit_rd[L-1:0];
  assign c_rd_1  = commit_rd[2*L-1:L];
  assign c_prd_0 = commit_prd[P-1:0];
  assign c_prd_1 = commit_prd[2*P-1:P];

  // --------------------------------------------------------------------
  // Allocation need and acceptance
  // --------------------------------------------------------------------
  // Writes to architectural register 0 are discarded, so they never
  // consume a physical register.
  logic                      need_0, need_1;
  logic [1:0]                needed;
  logic [FREE_CNT_WIDTH-1:0] needed_ext;
  logic                      fire;

  assign need_0     = in_slot_valid[0] && in_rd_wen[0] && (rd_0 != '0);
  assign need_1     = in_slot_valid[1] && in_rd_wen[1] && (rd_1 != '0);
  assign needed     = {1'b0, need_0} + {1'b0, need_1};
  assign needed_ext = {{(FREE_CNT_WIDTH-2){1'b0}}, needed};

  // The whole group waits unless every needed register is available, so
  // the freelist never sees a partial allocation.
  assign in_ready = !flush && (!out_valid || out_ready) && (free_count >= needed_ext);
  assign fire     = in_valid && in_ready;

  assign alloc0_valid = fire && (needed != 2'd0);
  assign alloc1_valid = fire && (needed == 2'd2);

  // --------------------------------------------------------------------
  // Destination steering: the first writing slot always takes head.
  // --------------------------------------------------------------------
  logic [P-1:0] new_prd_0, new_prd_1;

  assign new_prd_0 = need_0 ? alloc0_data : '0;
  assign new_prd_1 = need_1 ? (need_0 ? alloc1_data : alloc0_data) : '0;

  // --------------------------------------------------------------------
  // Speculative map lookups (index 0 is hard-wired to physical 0)
  // --------------------------------------------------------------------
  logic [P-1:0] sp_rs1_0, sp_rs1_1, sp_rs2_0, sp_rs2_1, sp_rd_0, sp_rd_1;

  assign sp_rs1_0 = (rs1_0 == '0) ? '0 : spec_map[rs1_0];
  assign sp_rs1_1 = (rs1_1 == '0) ? '0 : spec_map[rs1_1];
  assign sp_rs2_0 = (rs2_0 == '0) ? '0 : spec_map[rs2_0];
  assign sp_rs2_1 = (rs2_1 == '0) ? '0 : spec_map[rs2_1];
  assign sp_rd_0  = (rd_0  == '0) ? '0 : spec_map[rd_0];
  assign sp_rd_1  = (rd_1  == '0) ? '0 : spec_map[rd_1];

  // Slot 1 sees slot 0's write in the same group (intra-group bypass).
  // rs == rd_0 with need_0 implies rs != 0, so index 0 stays at 0.
  logic [P-1:0] prs1_0, prs1_1, prs2_0, prs2_1, old_prd_0, old_prd_1;

  assign prs1_0 = sp_rs1_0;
  assign prs2_0 = sp_rs2_0;
  assign prs1_1 = (need_0 && (rs1_1 == rd_0)) ? new_prd_0 : sp_rs1_1;
  assign prs2_1 = (need_0 && (rs2_1 == rd_0)) ? new_prd_0 : sp_rs2_1;

  // When both slots write the same rd, the mapping slot 1 displaces is
  // the one slot 0 just created, not the one in the map.
  assign old_prd_0 = need_0 ? sp_rd_0 : '0;
  assign old_prd_1 = need_1 ? ((need_0 && (rd_1 == rd_0)) ? new_prd_0 : sp_rd_1) : '0;

  // --------------------------------------------------------------------
  // Architectural map with this cycle's commits applied. A flush copies
  // this view, so commits arriving together with a flush are kept.
  // Slot 1 is applied last so it wins on a shared rd.
  // --------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) begin
      arch_map_nxt[i] = arch_map[i];
      if (commit_valid[0] && (c_rd_0 != '0) && (c_rd_0 == L'(i)))
        arch_map_nxt[i] = c_prd_0;
      if (commit_valid[1] && (c_rd_1 != '0) && (c_rd_1 == L'(i)))
        arch_map_nxt[i] = c_prd_1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++)
        arch_map[i] <= P'(i);
    end else begin
      for (int i = 0; i < ARCH_REGS; i++)
        arch_map[i] <= arch_map_nxt[i];
    end
  end

  // --------------------------------------------------------------------
  // Speculative map. fire is never set during flush (in_ready is low),
  // so the two branches are exclusive in practice.
  // --------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++)
        spec_map[i] <= P'(i);
    end else if (flush) begin
      for (int i = 0; i < ARCH_REGS; i++)
        spec_map[i] <= arch_map_nxt[i];
    end else if (fire) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        if (need_1 && (rd_1 == L'(i)))
          spec_map[i] <= new_prd_1;
        else if (need_0 && (rd_0 == L'(i)))
          spec_map[i] <= new_prd_0;
      end
    end
  end

  // --------------------------------------------------------------------
  // Output register. A flush drops any group still waiting downstream.
  // --------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_slot_valid <= '0;
      out_prs1       <= '0;
      out_prs2       <= '0;
      out_prd        <= '0;
      out_old_prd    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid      <= 1'b1;
      out_slot_valid <= in_slot_valid;
      out_prs1       <= {prs1_1, prs1_0};
      out_prs2       <= {prs2_1, prs2_0};
      out_prd        <= {new_prd_1, new_prd_0};
      out_old_prd    <= {old_prd_1, old_prd_0};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RENAME_STALL_CNT_EN
  // Counts only freelist starvation; downstream back-pressure is not counted.
  logic stall_evt;
  assign stall_evt = in_valid && !flush && (free_count < needed_ext);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall_evt && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rename_map_table.sv
// Testbench for rename_map_table: directed scenarios followed by random
// traffic, all checked against a behavioural model of the rename rules.

module tb_rename_map_table;

  localparam int GW = 2 + 8*6;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_slot_valid;
  logic [9:0]  in_rs1, in_rs2, in_rd;
  logic [1:0]  in_rd_wen;
  logic [5:0]  free_count;
  logic        alloc0_valid, alloc1_valid;
  logic [5:0]  alloc0_data, alloc1_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_slot_valid;
  logic [11:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_rd;
  logic [11:0] commit_prd;
  logic        flush;
`ifdef RENAME_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  rename_map_table dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_slot_valid(in_slot_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .free_count(free_count),
    .alloc0_valid(alloc0_valid), .alloc0_data(alloc0_data),
    .alloc1_valid(alloc1_valid), .alloc1_data(alloc1_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_slot_valid(out_slot_valid), .out_prs1(out_prs1), .out_prs2(out_prs2),
    .out_prd(out_prd), .out_old_prd(out_old_prd),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_prd(commit_prd),
`ifdef RENAME_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .flush(flush)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard and reference model
  int errors = 0;
  int checks = 0;
  logic [GW-1:0] exp_q[$];
  logic [5:0]    m_spec [32];
  logic [5:0]    m_arch [32];
  logic [31:0]   m_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_spec[i] = 6'(i);
      m_arch[i] = 6'(i);
    end
    m_stall = 0;
    exp_q.delete();
  endtask

  function automatic logic [5:0] look(input logic [4:0] r);
    return (r == 5'd0) ? 6'd0 : m_spec[r];
  endfunction

  // One clock cycle: check at the falling edge, advance the model at the
  // rising edge, return 1 time unit after it so the caller can drive inputs.
  task automatic step();
    logic       n0, n1, exp_ready, exp_fire, pop;
    int         needed;
    logic [4:0] rd0, rd1, a0, a1, b0, b1;
    logic [5:0] p0, p1, s1a, s1b, old0, old1;
    @(negedge clock);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0)
      check("out_group", {out_slot_valid, out_prs1, out_prs2, out_prd, out_old_prd}, exp_q[0]);
    rd0 = in_rd[4:0];  rd1 = in_rd[9:5];
    a0  = in_rs1[4:0]; a1  = in_rs1[9:5];
    b0  = in_rs2[4:0]; b1  = in_rs2[9:5];
    n0 = in_slot_valid[0] && in_rd_wen[0] && rd0 != 0;
    n1 = in_slot_valid[1] && in_rd_wen[1] && rd1 != 0;
    needed = int'(n0) + int'(n1);
    exp_ready = !flush && (exp_q.size() == 0 || out_ready) && int'(free_count) >= needed;
    exp_fire = in_valid && exp_ready;
    check("in_ready", in_ready, exp_ready);
    check("alloc0_valid", alloc0_valid, exp_fire && needed >= 1);
    check("alloc1_valid", alloc1_valid, exp_fire && needed == 2);
`ifdef RENAME_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
    p0 = n0 ? alloc0_data : 6'd0;
    p1 = n1 ? (n0 ? alloc1_data : alloc0_data) : 6'd0;
    s1a = (n0 && a1 == rd0) ? p0 : look(a1);
    s1b = (n0 && b1 == rd0) ? p0 : look(b1);
    old0 = n0 ? look(rd0) : 6'd0;
    old1 = n1 ? ((n0 && rd1 == rd0) ? p0 : look(rd1)) : 6'd0;
    pop = out_ready && exp_q.size() != 0;
    @(posedge clock);
    if (in_valid && !flush && int'(free_count) < needed && m_stall != 32'hFFFF_FFFF)
      m_stall++;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (exp_fire)
        exp_q.push_back({in_slot_valid, s1a, look(a0), s1b, look(b0), p1, p0, old1, old0});
    end
    if (exp_fire) begin
      if (n0) m_spec[rd0] = p0;
      if (n1) m_spec[rd1] = p1;
    end
    for (int k = 0; k < 2; k++)
      if (commit_valid[k] && commit_rd[k*5 +: 5] != 0)
        m_arch[commit_rd[k*5 +: 5]] = commit_prd[k*6 +: 6];
    if (flush)
      for (int i = 0; i < 32; i++) m_spec[i] = m_arch[i];
    #1;
  endtask

  // driver tasks
  task automatic drive_idle();
    in_valid = 0; in_slot_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wen = 0;
    free_count = 6'd32; alloc0_data = 0; alloc1_data = 0; out_ready = 1;
    commit_valid = 0; commit_rd = 0; commit_prd = 0; flush = 0;
  endtask

  task automatic drive_group(input logic [1:0] sv, input logic [1:0] wen,
                             input logic [4:0] rd0, input logic [4:0] rs1_0, input logic [4:0] rs2_0,
                             input logic [4:0] rd1, input logic [4:0] rs1_1, input logic [4:0] rs2_1);
    in_valid = 1; in_slot_valid = sv; in_rd_wen = wen;
    in_rd = {rd1, rd0}; in_rs1 = {rs1_1, rs1_0}; in_rs2 = {rs2_1, rs2_0};
  endtask

  task automatic drive_random();
    in_valid      = $urandom_range(0, 3) != 0;
    in_slot_valid = 2'($urandom_range(0, 3));
    in_rd_wen     = 2'($urandom_range(0, 3));
    in_rd         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    in_rs1        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    in_rs2        = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 7))};
    free_count    = 6'($urandom_range(0, 4));
    alloc0_data   = 6'($urandom_range(1, 63));
    alloc1_data   = 6'($urandom_range(1, 63));
    out_ready     = $urandom_range(0, 3) != 0;
    commit_valid  = 2'($urandom_range(0, 3));
    commit_rd     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    commit_prd    = {6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
    flush         = $urandom_range(0, 19) == 0;
  endtask

  initial begin
    drive_idle();
    reset = 1;
    model_reset();
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_prd", out_prd, 12'd0);
    check("rst_out_old_prd", out_old_prd, 12'd0);
    check("rst_alloc0", alloc0_valid, 1'b0);
    check("rst_alloc1", alloc1_valid, 1'b0);
    reset = 0;
    #5;

    // two-slot group with intra-group dependency
    drive_group(2'b11, 2'b11, 5'd5, 5'd3, 5'd0, 5'd6, 5'd5, 5'd0);
    alloc0_data = 6'd32; alloc1_data = 6'd33;
    step();
    check("dep_prd", out_prd, {6'd33, 6'd32});
    check("dep_old_prd", out_old_prd, {6'd6, 6'd5});
    check("dep_prs1", out_prs1, {6'd32, 6'd3});

    // slot 0 writes x0: only one allocation, slot 1 takes head
    drive_group(2'b11, 2'b11, 5'd0, 5'd1, 5'd2, 5'd7, 5'd1, 5'd2);
    alloc0_data = 6'd40; alloc1_data = 6'd41;
    step();
    check("x0_prd", out_prd, {6'd40, 6'd0});

    // both slots write the same rd
    drive_group(2'b11, 2'b11, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0);
    alloc0_data = 6'd34; alloc1_data = 6'd35;
    step();
    check("same_rd_old1", out_old_prd[11:6], 6'd34);
    drive_group(2'b01, 2'b00, 5'd0, 5'd9, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    check("same_rd_lookup", out_prs1[5:0], 6'd35);

    // freelist starvation then release
    drive_group(2'b11, 2'b11, 5'd10, 5'd0, 5'd0, 5'd11, 5'd0, 5'd0);
    alloc0_data = 6'd42; alloc1_data = 6'd43; free_count = 6'd1;
    repeat (3) step();
    free_count = 6'd2;
    step();
    check("starve_release_prd", out_prd, {6'd43, 6'd42});
    free_count = 6'd32;

    // flush without and with a same-cycle commit
    for (int pass = 0; pass < 2; pass++) begin
      drive_group(2'b01, 2'b01, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      alloc0_data = 6'd36;
      step();
      in_valid = 0; flush = 1;
      if (pass == 1) begin
        commit_valid = 2'b01; commit_rd = {5'd0, 5'd4}; commit_prd = {6'd0, 6'd36};
      end
      step();
      flush = 0; commit_valid = 0;
      drive_group(2'b01, 2'b00, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0);
      step();
      check("flush_lookup", out_prs1[5:0], (pass == 1) ? 6'd36 : 6'd4);
    end

    // downstream stall, then reset while stalled
    drive_group(2'b11, 2'b11, 5'd12, 5'd1, 5'd0, 5'd13, 5'd12, 5'd0);
    alloc0_data = 6'd50; alloc1_data = 6'd51; out_ready = 0;
    step();
    repeat (3) step();
    in_valid = 0;
    reset = 1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    model_reset();
    #10;
    reset = 0;
    drive_group(2'b01, 2'b00, 5'd0, 5'd12, 5'd9, 5'd0, 5'd0, 5'd0);
    out_ready = 1;
    step();
    check("midrst_identity", out_prs1[5:0], 6'd12);
    check("midrst_identity2", out_prs2[5:0], 6'd9);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      drive_random();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
